spi_master: RTL and testbench
=============================

# spi_master

SPI master that serialises one WIDTH-bit word per transfer onto MOSI while capturing WIDTH bits from MISO. It frames each transfer with CS and generates SCLK from the system clock through a programmable divider. It sits between the host logic (start/data/done handshake) and the SPI pins of the team's SPI slave peripherals. Link convention:
- SCLK idles low.
- Slave samples MOSI on SCLK fall and drives MISO on SCLK rise.
- MSB first on both lines.

## Interface
- `WIDTH`, 8: bits per transfer, ≥ 1.
- `CLK_DIV`, 4: SCLK half-period in CLK cycles, ≥ 1.

Ports:
- `CLK`  in  1  system clock. One clock; reset is synchronous and active-high.
- `RST`  in  1  synchronous, active-high reset.
- `start`  in  1  transfer request; accepted only when `busy`=0.
- `tx_data`  in  WIDTH  word to send; latched on the accepting cycle.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse at transfer end.
- `rx_data`  out  WIDTH  last received word; valid from the `done` cycle, held until the next `done`.
- `SCLK`  out  1  serial clock.
- `CS`  out  1  chip select, active low.
- `MOSI`  out  1  serial data out.
- `MISO`  in  1  serial data in; may be Z or X while CS is high, and is ignored then.

## Operation
- Reset values: `CS`=1, `SCLK`=0, `MOSI`=0, `busy`=0, `done`=0, `rx_data`=0. `RST` has priority over all other activity.
- FSM states: IDLE, LEAD, HIGH, LOW, END.
- **IDLE:**
  - `start`=1: latch `tx_data` into tx_shift, clear the bit counter, go to LEAD.
  - `start` while `busy`=1 is ignored. It is not queued.
- **LEAD** (CLK_DIV cycles):
  - `CS`=0, `SCLK`=0, `MOSI`=tx_shift[MSB].
  - Then go to HIGH.
- **HIGH** (CLK_DIV cycles):
  - On entry, `SCLK`=1 and `MOSI`=current bit.
  - `MOSI` changes only on entry to HIGH, so it is stable for CLK_DIV cycles before the falling edge.
- **LOW** (CLK_DIV cycles):
  - On entry, `SCLK`=0 and MISO is sampled into rx_shift (shift left, LSB in). tx_shift shifts left and the bit counter increments.
  - After CLK_DIV cycles: if counter < WIDTH go to HIGH, else go to END.
  - The final LOW period serves as CS hold time.
- **END** (1 cycle):
  - `CS`=1, `SCLK`=0, `done`=1, `busy`=0, `rx_data`←rx_shift, go to IDLE.
  - A `start` in this cycle is accepted, giving back-to-back transfers with CS high for exactly 1 cycle.
- `busy`=1 in LEAD, HIGH and LOW; `busy`=0 in IDLE and END.
- `MOSI` holds its last value after END. This value is don't-care while CS=1.
- Bit counter width is $clog2(WIDTH+1). Divider counter width is $clog2(CLK_DIV+1). Neither counter wraps within a transfer.
- `RST` mid-transfer: the next cycle shows the reset values. No `done` is produced, and the partial rx is discarded (`rx_data`=0).

## Timing
- `start` accepted at CLK edge 0:
  - CS falls at edge 1.
  - First SCLK rise at edge 1+CLK_DIV.
  - k-th SCLK fall (k=1..WIDTH) at edge 1+CLK_DIV·2k.
  - `done` and CS rise at edge 1+CLK_DIV·(2·WIDTH+1).
- Defaults give `done` at edge 69.
- SCLK period is 2·CLK_DIV CLK cycles with 50 % duty.
- MISO is sampled CLK_DIV cycles after the slave's launch edge (SCLK rise).
- Maximum throughput: one transfer per CLK_DIV·(2·WIDTH+1)+1 cycles.

## Structure
- Package `spi_pkg` holds the FSM state enum and the link convention constants: SCLK idle level 0, MSB-first flag.
- Sub-module `spi_sclk_gen` is a CLK_DIV down-counter that emits a one-cycle half-period tick. It is reloaded on state entry.
- Shift registers and FSM live in `spi_master`.

## Test plan
- **Reset state:** hold `RST` 3 cycles → `CS`=1, `SCLK`=0, `MOSI`=0, `busy`=0, `done`=0, `rx_data`=0.
- **Single transfer, defaults:**
  - Stimulus: `tx_data`=8'hA5, pulse `start`.
  - Required: MOSI sampled at SCLK falls reads 1,0,1,0,0,1,0,1; exactly 8 SCLK pulses; `done` at edge 69.
  - Required: bench slave driving 8'h3C on MISO (changing on SCLK rise) → `rx_data`=8'h3C.
- **Loopback:**
  - Stimulus: bench slave echoes its previous received byte; send 8'h5A then 8'hC3 back-to-back (`start` in the `done` cycle).
  - Required: second `rx_data`=8'h5A, CS high exactly 1 cycle between frames.
- **Ignored start:** `start` pulses during `busy` with `tx_data`=8'hFF → the transfer in progress still shifts its original word, and no extra frame occurs.
- **CLK_DIV=1, WIDTH=16:**
  - Stimulus: send 16'h8001.
  - Required: SCLK toggles every cycle, `done` at edge 34, and the MSB and LSB are observed correctly.
- **Mid-transfer reset:** assert `RST` after the 3rd SCLK fall → next cycle `CS`=1, `busy`=0, no `done`, `rx_data`=0. A following transfer of 8'h81 then completes correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared types and link constants
// for the SPI master and its clock divider.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_HIGH,
    ST_LOW,
    ST_END
  } spi_state_e;

  localparam logic SCLK_IDLE = 1'b0;
  localparam bit   MSB_FIRST = 1'b1;

endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: half-period down-counter,
// reloaded on every FSM state entry.
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic tick
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] RELOAD = DW'(CLK_DIV);
  localparam logic [DW-1:0] ONE    = DW'(1);
  localparam logic [DW-1:0] ZERO   = '0;

  logic [DW-1:0] cnt_q;
  logic [DW-1:0] cnt_d;

  // reload on entry, else count down and park at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (cnt_q != ZERO) begin
      cnt_d = cnt_q - ONE;
    end
  end

  // counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // last cycle of the half period
  assign tick = (cnt_q == ONE);

endmodule

// File: rtl/spi_master.sv
// spi_master: one WIDTH-bit full-duplex transfer
// per start, CS framed, SCLK idle low.
module spi_master
  import spi_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             SCLK,
  output logic             CS,
  output logic             MOSI,
  input  logic             MISO
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);
  localparam logic [CW-1:0] INC  = CW'(1);

  spi_state_e state_q;
  spi_state_e state_d;

  logic [WIDTH-1:0] tx_shift_q;
  logic [WIDTH-1:0] tx_shift_d;
  logic [WIDTH-1:0] rx_shift_q;
  logic [WIDTH-1:0] rx_shift_d;
  logic [WIDTH-1:0] rx_data_q;
  logic [WIDTH-1:0] rx_data_d;
  logic [CW-1:0]    bit_cnt_q;
  logic [CW-1:0]    bit_cnt_d;

  logic cs_q;
  logic cs_d;
  logic sclk_q;
  logic sclk_d;
  logic mosi_q;
  logic mosi_d;
  logic busy_q;
  logic busy_d;
  logic done_q;
  logic done_d;

  logic div_load;
  logic div_tick;

  function automatic logic out_bit(
    input logic [WIDTH-1:0] w
  );
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(
    input logic [WIDTH-1:0] w
  );
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] shift_in(
    input logic [WIDTH-1:0] w,
    input logic             b
  );
    logic [WIDTH:0] ext;
    ext = MSB_FIRST ? {w, b} : ({b, w} >> 1);
    return ext[WIDTH-1:0];
  endfunction

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk  (CLK),
    .rst  (RST),
    .load (div_load),
    .tick (div_tick)
  );

  // restart the half-period timer whenever the state changes
  assign div_load = (state_d != state_q);

  // next-state and registered-output logic of the transfer FSM
  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    cs_d       = cs_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_END: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d    = ST_LEAD;
          tx_shift_d = tx_data;
          rx_shift_d = '0;
          bit_cnt_d  = '0;
          cs_d       = 1'b0;
          sclk_d     = SCLK_IDLE;
          mosi_d     = out_bit(tx_data);
          busy_d     = 1'b1;
        end
      end
      ST_LEAD: begin
        if (div_tick) begin
          state_d = ST_HIGH;
          sclk_d  = ~SCLK_IDLE;
          mosi_d  = out_bit(tx_shift_q);
        end
      end
      ST_HIGH: begin
        if (div_tick) begin
          state_d    = ST_LOW;
          sclk_d     = SCLK_IDLE;
          rx_shift_d = shift_in(rx_shift_q, MISO);
          tx_shift_d = shift_out(tx_shift_q);
          bit_cnt_d  = bit_cnt_q + INC;
        end
      end
      ST_LOW: begin
        if (div_tick) begin
          if (bit_cnt_q < LAST) begin
            state_d = ST_HIGH;
            sclk_d  = ~SCLK_IDLE;
            mosi_d  = out_bit(tx_shift_q);
          end else begin
            state_d   = ST_END;
            cs_d      = 1'b1;
            sclk_d    = SCLK_IDLE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            rx_data_d = rx_shift_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cs_d    = 1'b1;
        sclk_d  = SCLK_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // state and output registers; reset wins over everything
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      cs_q       <= 1'b1;
      sclk_q     <= SCLK_IDLE;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      cs_q       <= cs_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign SCLK    = sclk_q;
  assign CS      = cs_q;
  assign MOSI    = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed vectors for the
// default and the WIDTH=16/CLK_DIV=1 builds.
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // default instance
  logic       rst0;
  logic       start0;
  logic [7:0] tx0;
  logic       busy0;
  logic       done0;
  logic [7:0] rx0;
  logic       sclk0;
  logic       cs0;
  logic       mosi0;
  logic       miso0 = 1'b0;

  spi_master #(.WIDTH(8), .CLK_DIV(4)) dut0 (
    .CLK     (clk),
    .RST     (rst0),
    .start   (start0),
    .tx_data (tx0),
    .busy    (busy0),
    .done    (done0),
    .rx_data (rx0),
    .SCLK    (sclk0),
    .CS      (cs0),
    .MOSI    (mosi0),
    .MISO    (miso0)
  );

  // wide, fast instance
  logic        rst1;
  logic        start1;
  logic [15:0] tx1;
  logic        busy1;
  logic        done1;
  logic [15:0] rx1;
  logic        sclk1;
  logic        cs1;
  logic        mosi1;
  logic        miso1 = 1'b0;

  spi_master #(.WIDTH(16), .CLK_DIV(1)) dut1 (
    .CLK     (clk),
    .RST     (rst1),
    .start   (start1),
    .tx_data (tx1),
    .busy    (busy1),
    .done    (done1),
    .rx_data (rx1),
    .SCLK    (sclk1),
    .CS      (cs1),
    .MOSI    (mosi1),
    .MISO    (miso1)
  );

  // slave model 0: drives on SCLK rise, samples on fall
  bit         echo0 = 1'b0;
  logic [7:0] cfg0 = 8'h00;
  logic [7:0] cur0 = 8'h00;
  logic [7:0] srx0 = 8'h00;
  logic [7:0] last0 = 8'h00;
  int         rise0 = 0;
  int         fall0 = 0;
  int         frames0 = 0;
  logic       p_cs0 = 1'b1;
  logic       p_sclk0 = 1'b0;

  always @(cs0, sclk0) begin
    if (p_cs0 === 1'b1 && cs0 === 1'b0) begin
      cur0 = echo0 ? last0 : cfg0;
      srx0 = 8'h00;
      rise0 = 0;
      fall0 = 0;
      frames0++;
    end
    if (p_cs0 === 1'b0 && cs0 === 1'b1) last0 = srx0;
    if (p_sclk0 === 1'b0 && sclk0 === 1'b1) begin
      miso0 = cur0[7];
      cur0 = cur0 << 1;
      rise0++;
    end
    if (p_sclk0 === 1'b1 && sclk0 === 1'b0) begin
      srx0 = {srx0[6:0], mosi0};
      fall0++;
    end
    p_cs0 = cs0;
    p_sclk0 = sclk0;
  end

  // slave model 1
  logic [15:0] cfg1 = 16'h0000;
  logic [15:0] cur1 = 16'h0000;
  logic [15:0] srx1 = 16'h0000;
  int          fall1 = 0;
  logic        p_cs1 = 1'b1;
  logic        p_sclk1 = 1'b0;

  always @(cs1, sclk1) begin
    if (p_cs1 === 1'b1 && cs1 === 1'b0) begin
      cur1 = cfg1;
      srx1 = 16'h0000;
      fall1 = 0;
    end
    if (p_sclk1 === 1'b0 && sclk1 === 1'b1) begin
      miso1 = cur1[15];
      cur1 = cur1 << 1;
    end
    if (p_sclk1 === 1'b1 && sclk1 === 1'b0) begin
      srx1 = {srx1[14:0], mosi1};
      fall1++;
    end
    p_cs1 = cs1;
    p_sclk1 = sclk1;
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // called #1 after an edge; start is sampled on the next edge
  task automatic xfer0(input logic [7:0] tx,
                       output logic cs_e1,
                       output logic busy_e1,
                       output int dedge);
    int e0;
    tx0 = tx;
    start0 = 1'b1;
    e0 = cyc;
    @(posedge clk); #1;
    start0 = 1'b0;
    cs_e1 = cs0;
    busy_e1 = busy0;
    for (int i = 0; i < 200 && done0 !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    dedge = (done0 === 1'b1) ? (cyc - e0) : -1;
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] stx;
    logic [7:0] exp_rx;
    logic [7:0] exp_mosi;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic c1;
    logic b1;
    int   de;
    int   f;
    int   e0;
    int   tog;
    logic prev;

    vecs[0] = '{8'hA5, 8'h3C, 8'h3C, 8'hA5};
    vecs[1] = '{8'h00, 8'hFF, 8'hFF, 8'h00};
    vecs[2] = '{8'hFF, 8'h00, 8'h00, 8'hFF};
    vecs[3] = '{8'h81, 8'h7E, 8'h7E, 8'h81};
    vecs[4] = '{8'h5A, 8'hA5, 8'hA5, 8'h5A};

    rst0 = 1'b1;
    rst1 = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    tx0 = 8'h00;
    tx1 = 16'h0000;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", cs0, 1);
    check("rst_sclk", sclk0, 0);
    check("rst_mosi", mosi0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_rx", rx0, 0);
    rst0 = 1'b0;
    rst1 = 1'b0;

    // table: single transfers at default parameters
    foreach (vecs[k]) begin
      cfg0 = vecs[k].stx;
      @(posedge clk); #1;
      xfer0(vecs[k].tx, c1, b1, de);
      check($sformatf("v%0d_cs_fall", k), c1, 0);
      check($sformatf("v%0d_busy", k), b1, 1);
      check($sformatf("v%0d_done_edge", k), de, 69);
      check($sformatf("v%0d_rx", k), rx0, vecs[k].exp_rx);
      check($sformatf("v%0d_mosi", k), srx0, vecs[k].exp_mosi);
      check($sformatf("v%0d_pulses", k), rise0, 8);
      check($sformatf("v%0d_cs_end", k), cs0, 1);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", k), done0, 0);
    end

    // loopback, back-to-back with start in the done cycle
    echo0 = 1'b1;
    @(posedge clk); #1;
    xfer0(8'h5A, c1, b1, de);
    check("lb1_done_edge", de, 69);
    check("lb_cs_gap_hi", cs0, 1);
    xfer0(8'hC3, c1, b1, de);
    check("lb_cs_gap_lo", c1, 0);
    check("lb2_done_edge", de, 69);
    check("lb2_rx", rx0, 8'h5A);
    check("lb2_mosi", srx0, 8'hC3);
    echo0 = 1'b0;

    // start pulses while busy must not disturb the frame
    cfg0 = 8'h3C;
    @(posedge clk); #1;
    f = frames0;
    tx0 = 8'hA5;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    tx0 = 8'hFF;
    for (int i = 0; i < 200 && done0 !== 1'b1; i++) begin
      @(posedge clk); #1;
      start0 = (done0 !== 1'b1 && (i % 10) == 3);
    end
    start0 = 1'b0;
    check("ign_done", done0, 1);
    check("ign_mosi", srx0, 8'hA5);
    check("ign_rx", rx0, 8'h3C);
    repeat (100) @(posedge clk);
    #1;
    check("ign_frames", frames0 - f, 1);
    check("ign_cs_idle", cs0, 1);

    // reset after the third SCLK fall
    cfg0 = 8'hA5;
    @(posedge clk); #1;
    tx0 = 8'h3C;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int i = 0; i < 200 && fall0 < 3; i++) begin
      @(posedge clk); #1;
    end
    check("mr_falls", fall0, 3);
    rst0 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0;
    check("mr_cs", cs0, 1);
    check("mr_busy", busy0, 0);
    check("mr_done", done0, 0);
    check("mr_rx", rx0, 0);
    check("mr_sclk", sclk0, 0);
    cfg0 = 8'h42;
    @(posedge clk); #1;
    check("mr_no_done", done0, 0);
    xfer0(8'h81, c1, b1, de);
    check("mr2_done_edge", de, 69);
    check("mr2_rx", rx0, 8'h42);
    check("mr2_mosi", srx0, 8'h81);

    // WIDTH=16, CLK_DIV=1
    cfg1 = 16'hC003;
    @(posedge clk); #1;
    tx1 = 16'h8001;
    start1 = 1'b1;
    e0 = cyc;
    prev = sclk1;
    tog = 0;
    for (int i = 0; i < 200 && done1 !== 1'b1; i++) begin
      @(posedge clk); #1;
      start1 = 1'b0;
      if ((cyc - e0) >= 2 && (cyc - e0) <= 33 && sclk1 !== prev)
        tog++;
      prev = sclk1;
    end
    de = (done1 === 1'b1) ? (cyc - e0) : -1;
    check("w16_done_edge", de, 34);
    check("w16_toggles", tog, 32);
    check("w16_falls", fall1, 16);
    check("w16_msb", srx1[15], 1);
    check("w16_lsb", srx1[0], 1);
    check("w16_mosi", srx1, 16'h8001);
    check("w16_rx", rx1, 16'hC003);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
